testarray0_splitter: RTL and testbench

Consumer-side counterpart of the TestArray0 blocking interface. Accepts `int_2` arrays on a blocking input port and emits their elements, one per transfer, as `integer` values on a blocking output port. Sits downstream of any block producing `int_2` on a sync/notify port; its scalar output can feed an `integer` blocking input. All outputs are registered.

---
 rtl/testarray0_splitter_if.sv | 27 ++
 rtl/testarray0_splitter.sv | 118 +++++++++++
 tb/tb_testarray0_splitter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/testarray0_splitter_if.sv
// Array/element type package and the splitter's paired blocking-port interface
// (sync = requester side valid/accept, notify = splitter side ready/valid).
package testarray0_types;
  typedef logic [31:0]       int32_t;
  typedef logic [1:0][31:0]  int_2;
endpackage

interface testarray0_splitter_if;
  testarray0_types::int_2   arr_in;
  logic                     arr_in_sync;
  logic                     arr_in_notify;
  testarray0_types::int32_t elem_out;
  logic                     elem_out_sync;
  logic                     elem_out_notify;

  // Environment side: producer of arrays and consumer of elements.
  modport master (
    output arr_in, arr_in_sync, elem_out_sync,
    input  arr_in_notify, elem_out, elem_out_notify
  );

  // Splitter side.
  modport slave (
    input  arr_in, arr_in_sync, elem_out_sync,
    output arr_in_notify, elem_out, elem_out_notify
  );
endinterface

// File: rtl/testarray0_splitter.sv
// Splits an int_2 array into two integer transfers, first element valid 1 cycle after input transfer;
// elem_out_sync low stalls with stable outputs. TESTARRAY0_SPLITTER_ZERO_SKIP_EN drops zero elements.
module testarray0_splitter #(
  parameter int FIRST_IDX = 0
) (
  input logic                    clk,
  input logic                    rst,
  testarray0_splitter_if.slave   bus
);

  if (FIRST_IDX != 0 && FIRST_IDX != 1) begin : g_bad_first_idx
    $error("testarray0_splitter: FIRST_IDX must be 0 or 1");
  end

  localparam bit FI = (FIRST_IDX == 1);
  localparam bit SI = !FI;

`ifdef TESTARRAY0_SPLITTER_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_READ    = 2'd0,
    ST_WRITE_A = 2'd1,
    ST_WRITE_B = 2'd2
  } st_e;

  st_e                      st_q;
  testarray0_types::int_2   buf_q;
  testarray0_types::int32_t elem_q;
  logic                     elem_vld_q;
  logic                     arr_rdy_q;

  logic in_xfer;
  logic out_xfer;
  logic skip_first_in;
  logic skip_second_in;
  logic skip_second_buf;

  assign in_xfer         = arr_rdy_q & bus.arr_in_sync;
  assign out_xfer        = elem_vld_q & bus.elem_out_sync;
  assign skip_first_in   = ZERO_SKIP && (bus.arr_in[FI] == '0);
  assign skip_second_in  = ZERO_SKIP && (bus.arr_in[SI] == '0);
  assign skip_second_buf = ZERO_SKIP && (buf_q[SI] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_READ;
      buf_q      <= '0;
      elem_q     <= '0;
      elem_vld_q <= 1'b0;
      arr_rdy_q  <= 1'b1;
    end else begin
      case (st_q)
        ST_READ: begin
          if (in_xfer) begin
            buf_q <= bus.arr_in;
            if (!skip_first_in) begin
              elem_q     <= bus.arr_in[FI];
              elem_vld_q <= 1'b1;
              arr_rdy_q  <= 1'b0;
              st_q       <= ST_WRITE_A;
            end else if (!skip_second_in) begin
              // Leading zero dropped: go straight to the last-element state.
              elem_q     <= bus.arr_in[SI];
              elem_vld_q <= 1'b1;
              arr_rdy_q  <= 1'b0;
              st_q       <= ST_WRITE_B;
            end
          end
        end
        ST_WRITE_A: begin
          if (out_xfer) begin
            if (skip_second_buf) begin
              elem_vld_q <= 1'b0;
              arr_rdy_q  <= 1'b1;
              st_q       <= ST_READ;
            end else begin
              elem_q <= buf_q[SI];
              st_q   <= ST_WRITE_B;
            end
          end
        end
        ST_WRITE_B: begin
          if (out_xfer) begin
            elem_vld_q <= 1'b0;
            arr_rdy_q  <= 1'b1;
            st_q       <= ST_READ;
          end
        end
        default: begin
          elem_vld_q <= 1'b0;
          arr_rdy_q  <= 1'b1;
          st_q       <= ST_READ;
        end
      endcase
    end
  end

  assign bus.arr_in_notify   = arr_rdy_q;
  assign bus.elem_out        = elem_q;
  assign bus.elem_out_notify = elem_vld_q;

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (elem_vld_q && !bus.elem_out_sync) |=> (elem_vld_q && $stable(elem_q)));

  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(elem_vld_q && arr_rdy_q));

  a_write_a_data: assert property (@(posedge clk) disable iff (rst)
    (st_q == ST_WRITE_A) |-> (elem_q == buf_q[FI]));

  a_write_b_data: assert property (@(posedge clk) disable iff (rst)
    (st_q == ST_WRITE_B) |-> (elem_q == buf_q[SI]));

endmodule

// File: tb/tb_testarray0_splitter.sv
// Bench: two splitters (FIRST_IDX 0 and 1) share stimulus; a queue model checks both every cycle.
module tb_testarray0_splitter;

  logic clk;
  logic rst;
  logic [1:0][31:0] arr;
  logic a_sync;
  logic e_sync;

  int total;
  int bad;
  bit run_cmp;

`ifdef TESTARRAY0_SPLITTER_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  testarray0_splitter_if if0 ();
  testarray0_splitter_if if1 ();

  assign if0.arr_in        = arr;
  assign if0.arr_in_sync   = a_sync;
  assign if0.elem_out_sync = e_sync;
  assign if1.arr_in        = arr;
  assign if1.arr_in_sync   = a_sync;
  assign if1.elem_out_sync = e_sync;

  testarray0_splitter #(.FIRST_IDX(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  testarray0_splitter #(.FIRST_IDX(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each DUT owes the elements queued here, in emission order.
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] lg0[$];
  logic [31:0] lg1[$];
  logic [31:0] ex0[$];
  logic [31:0] ex1[$];

  function automatic bit keep(logic [31:0] v);
    return !ZS || (v != 32'd0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq0.delete();
      mq1.delete();
    end else begin
      if (mq0.size() != 0) begin
        if (e_sync) void'(mq0.pop_front());
      end else if (a_sync) begin
        if (keep(arr[0])) mq0.push_back(arr[0]);
        if (keep(arr[1])) mq0.push_back(arr[1]);
      end
      if (mq1.size() != 0) begin
        if (e_sync) void'(mq1.pop_front());
      end else if (a_sync) begin
        if (keep(arr[1])) mq1.push_back(arr[1]);
        if (keep(arr[0])) mq1.push_back(arr[0]);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(string nm, int qs, logic [31:0] qf, logic rdy, logic vld, logic [31:0] dat);
    chk({nm, ".arr_in_notify"}, {31'd0, rdy}, {31'd0, qs == 0});
    chk({nm, ".elem_out_notify"}, {31'd0, vld}, {31'd0, qs != 0});
    if (qs != 0) chk({nm, ".elem_out"}, dat, qf);
  endtask

  always @(negedge clk) begin
    if (!rst && run_cmp) begin
      cmp("m0", mq0.size(), (mq0.size() != 0) ? mq0[0] : 32'd0,
          if0.arr_in_notify, if0.elem_out_notify, if0.elem_out);
      cmp("m1", mq1.size(), (mq1.size() != 0) ? mq1[0] : 32'd0,
          if1.arr_in_notify, if1.elem_out_notify, if1.elem_out);
    end
    if (!rst && e_sync) begin
      if (if0.elem_out_notify) lg0.push_back(if0.elem_out);
      if (if1.elem_out_notify) lg1.push_back(if1.elem_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_rdy0"}, {31'd0, if0.arr_in_notify}, 32'd1);
    chk({nm, "_vld0"}, {31'd0, if0.elem_out_notify}, 32'd0);
    chk({nm, "_dat0"}, if0.elem_out, 32'd0);
    chk({nm, "_rdy1"}, {31'd0, if1.arr_in_notify}, 32'd1);
    chk({nm, "_vld1"}, {31'd0, if1.elem_out_notify}, 32'd0);
    chk({nm, "_dat1"}, if1.elem_out, 32'd0);
  endtask

  // Presents an array and returns #2 after the edge that accepted it.
  task automatic send(logic [31:0] a0, logic [31:0] a1);
    bit got;
    arr[0] = a0;
    arr[1] = a1;
    a_sync = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      got = if0.arr_in_notify;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_timeout: arr_in_notify stayed 0 for 40 cycles");
    end
    tick();
    a_sync = 1'b0;
  endtask

  task automatic drain();
    bit idle;
    e_sync = 1'b1;
    a_sync = 1'b0;
    idle = 1'b0;
    for (int c = 0; c < 40 && !idle; c++) begin
      @(negedge clk);
      idle = if0.arr_in_notify && if1.arr_in_notify;
    end
    total++;
    if (!idle) begin
      bad++;
      $display("FAIL drain_timeout: splitter never returned to READ");
    end
    tick();
  endtask

  task automatic check_logs(string nm);
    chk($sformatf("%s_count0", nm), lg0.size(), ex0.size());
    for (int i = 0; i < ex0.size() && i < lg0.size(); i++)
      chk($sformatf("%s_elem0[%0d]", nm, i), lg0[i], ex0[i]);
    chk($sformatf("%s_count1", nm), lg1.size(), ex1.size());
    for (int i = 0; i < ex1.size() && i < lg1.size(); i++)
      chk($sformatf("%s_elem1[%0d]", nm, i), lg1[i], ex1[i]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    run_cmp = 1'b0;
    rst     = 1'b1;
    arr     = '0;
    a_sync  = 1'b0;
    e_sync  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");
    run_cmp = 1'b1;

    // Basic order and latency with both syncs high.
    tick();
    e_sync = 1'b1;
    send(32'd5, 32'hFFFF_FFF9);
    @(negedge clk);
    chk("ord_c1_dat0", if0.elem_out, 32'd5);
    chk("ord_c1_dat1", if1.elem_out, 32'hFFFF_FFF9);
    chk("ord_c1_rdy0", {31'd0, if0.arr_in_notify}, 32'd0);
    tick();
    @(negedge clk);
    chk("ord_c2_dat0", if0.elem_out, 32'hFFFF_FFF9);
    chk("ord_c2_dat1", if1.elem_out, 32'd5);
    chk("ord_c2_vld0", {31'd0, if0.elem_out_notify}, 32'd1);
    tick();
    @(negedge clk);
    chk("ord_c3_rdy0", {31'd0, if0.arr_in_notify}, 32'd1);
    chk("ord_c3_vld0", {31'd0, if0.elem_out_notify}, 32'd0);
    tick();

    // Back-pressure in WRITE_A with ignored input pulses and changing data.
    e_sync = 1'b0;
    send(32'd5, 32'hFFFF_FFF9);
    for (int i = 0; i < 4; i++) begin
      a_sync = (i % 2 == 0);
      arr[0] = 32'd100 + 32'(i);
      arr[1] = 32'd200 + 32'(i);
      @(negedge clk);
      chk($sformatf("stall%0d_dat0", i), if0.elem_out, 32'd5);
      chk($sformatf("stall%0d_vld0", i), {31'd0, if0.elem_out_notify}, 32'd1);
      tick();
    end
    a_sync = 1'b0;
    e_sync = 1'b1;
    @(negedge clk);
    chk("stall_end_dat0", if0.elem_out, 32'd5);
    tick();
    @(negedge clk);
    chk("stall_buf_dat0", if0.elem_out, 32'hFFFF_FFF9);
    chk("stall_buf_dat1", if1.elem_out, 32'd5);
    tick();
    drain();

    // Asynchronous reset while an element is pending.
    e_sync = 1'b0;
    send(32'd11, 32'd22);
    @(negedge clk);
    chk("pre_rst_vld0", {31'd0, if0.elem_out_notify}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_rst");
    tick();

    // Zero elements streamed back to back.
    e_sync = 1'b1;
    lg0.delete();
    lg1.delete();
    send(32'd0, 32'd3);
    send(32'd0, 32'd0);
    send(32'd9, 32'd0);
    drain();
    repeat (2) tick();
    if (ZS) begin
      ex0 = '{32'd3, 32'd9};
      ex1 = '{32'd3, 32'd9};
    end else begin
      ex0 = '{32'd0, 32'd3, 32'd0, 32'd0, 32'd9, 32'd0};
      ex1 = '{32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd9};
    end
    check_logs("zeros");

    // Extreme values pass bit-exact.
    lg0.delete();
    lg1.delete();
    send(32'h8000_0000, 32'h7FFF_FFFF);
    drain();
    ex0 = '{32'h8000_0000, 32'h7FFF_FFFF};
    ex1 = '{32'h7FFF_FFFF, 32'h8000_0000};
    check_logs("bounds");

    // Random traffic on both handshakes, including zero-valued elements.
    for (int n = 0; n < 600; n++) begin
      a_sync = ($urandom_range(0, 2) != 0);
      e_sync = ($urandom_range(0, 3) != 0);
      arr[0] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      arr[1] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      tick();
    end
    drain();
    repeat (2) tick();

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
